rx_checked: RTL and testbench

Parametrised UART receiver; successor to the fixed 8N1 receiver in `hdl/comms`.
- Adds configurable parity and 1 or 2 stop bits.
- Rejects false start bits and reports parity, framing and overrun errors.
- Presents each byte on a valid/ready output with a one-entry holding register, so the packet parser can stall without corrupting a frame in flight.
- Sits between the pad-side `rx_in` pin and the comms command decoder.

---
 rtl/rx_checked.sv | 216 +++++++++++++++++++++
 tb/tb_rx_checked.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_checked.sv
// rx_checked: parametrised UART receiver with optional parity, 1/2 stop bits,
// false-start rejection, parity/framing/overrun reporting and a one-entry
// valid/ready holding register.
// Optional build macro: RX_MAJORITY_VOTE_EN (2-of-3 vote at counter 2,1,0).
module rx_checked #(
  parameter int CLK_BAUD_RATIO = 16,
  parameter int DATA_SIZE      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] HALF_LOAD = 16'(CLK_BAUD_RATIO / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLK_BAUD_RATIO - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(DATA_SIZE - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic                 hold_perr_q, hold_perr_d;
  logic                 hold_ferr_q, hold_ferr_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic rxs;
  logic sample;
  logic bit_val;
  logic complete;
  logic ferr_now;

  assign rxs    = sync2_q;
  assign sample = (cnt_q == '0);

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q, hist_d;

  // Keep the two previous synchronised samples for the 2-of-3 vote.
  always_comb begin
    hist_d = {hist_q[0], rxs};
  end

  // History register for majority voting.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) hist_q <= '1;
    else        hist_q <= hist_d;
  end

  // At counter 0, hist_q holds rxs from counter 2 and 1.
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  // Next-state logic: synchroniser, bit timing, frame FSM and holding register.
  always_comb begin
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    sh_d        = sh_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    hold_data_d = hold_data_q;
    hold_perr_d = hold_perr_q;
    hold_ferr_d = hold_ferr_q;
    valid_d     = valid_q;
    ovr_d       = 1'b0;
    complete    = 1'b0;
    ferr_now    = ferr_q;

    if (valid_q && ready_in) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (sample) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            cnt_d   = FULL_LOAD;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          sh_d  = {bit_val, sh_q[DATA_SIZE-1:1]};
          cnt_d = FULL_LOAD;
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_d  = ((^sh_q) ^ bit_val) != (PARITY_MODE == 2);
          state_d = S_STOP;
          cnt_d   = FULL_LOAD;
        end
      end
      S_STOP: begin
        if (sample) begin
          ferr_now = ferr_q | ~bit_val;
          ferr_d   = ferr_now;
          if (stop_q == LAST_STOP) begin
            complete = 1'b1;
            state_d  = (ferr_now && !bit_val) ? S_BREAK : S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
            cnt_d  = FULL_LOAD;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A transfer on the completion cycle frees the register, so the new
    // frame reloads it and valid stays high.
    if (complete) begin
      if (!valid_q || ready_in) begin
        hold_data_d = sh_q;
        hold_perr_d = perr_q;
        hold_ferr_d = ferr_now;
        valid_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      sh_q        <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      hold_data_q <= '0;
      hold_perr_q <= 1'b0;
      hold_ferr_q <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      sh_q        <= sh_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      hold_data_q <= hold_data_d;
      hold_perr_q <= hold_perr_d;
      hold_ferr_q <= hold_ferr_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out       = hold_data_q;
  assign valid_out      = valid_q;
  assign parity_err_out = hold_perr_q;
  assign frame_err_out  = hold_ferr_q;
  assign overrun_out    = ovr_q;
  assign busy_out       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_checked.sv
// Scoreboard bench for rx_checked: an 8N1 instance and an even-parity instance.
module tb_rx_checked;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1, ready0, ready1;
  logic [7:0] data0, data1;
  logic valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

  int total = 0;
  int bad   = 0;
  int vcnt0 = 0;
  int ov0   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rx_checked #(.CLK_BAUD_RATIO(16), .DATA_SIZE(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx0), .data_out(data0), .valid_out(valid0),
    .ready_in(ready0), .parity_err_out(perr0), .frame_err_out(ferr0),
    .overrun_out(ovr0), .busy_out(busy0)
  );

  rx_checked #(.CLK_BAUD_RATIO(16), .DATA_SIZE(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx1), .data_out(data1), .valid_out(valid1),
    .ready_in(ready1), .parity_err_out(perr1), .frame_err_out(ferr1),
    .overrun_out(ovr1), .busy_out(busy1)
  );

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: compare every transfer against the scoreboard heads.
  always @(negedge clk) begin
    exp_t e;
    if (valid0 && ready0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected: got frame 0x%0h want no frame", data0);
      end else begin
        e = q0.pop_front();
        chk("dut0_data", int'(data0), int'(e.d));
        chk("dut0_perr", int'(perr0), int'(e.p));
        chk("dut0_ferr", int'(ferr0), int'(e.f));
      end
    end
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected: got frame 0x%0h want no frame", data1);
      end else begin
        e = q1.pop_front();
        chk("dut1_data", int'(data1), int'(e.d));
        chk("dut1_perr", int'(perr1), int'(e.p));
        chk("dut1_ferr", int'(ferr1), int'(e.f));
      end
    end
    if (valid0) vcnt0++;
    if (ovr0)   ov0++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  // One bit time; g inverts the single cycle that lands on the sample point.
  task automatic drive_bit(input int sel, input logic b, input bit g);
    for (int j = 0; j < 16; j++) begin
      set_rx(sel, (g && j == 8) ? ~b : b);
      tick();
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop_v, input int glitch_bit);
    logic [7:0] dv;
    dv = d;
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, dv[i], glitch_bit == i);
    if (par_en) drive_bit(sel, par_bit, 1'b0);
    drive_bit(sel, stop_v, 1'b0);
  endtask

  task automatic idle(input int sel, input int bits);
    set_rx(sel, 1'b1);
    repeat (bits * 16) tick();
  endtask

  initial begin
    int v_before;
    bit saw_busy;
    logic [7:0] b3c;

    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    repeat (4) tick();
    chk("rst_data0",  int'(data0),  0);
    chk("rst_valid0", int'(valid0), 0);
    chk("rst_perr0",  int'(perr0),  0);
    chk("rst_ferr0",  int'(ferr0),  0);
    chk("rst_ovr0",   int'(ovr0),   0);
    chk("rst_busy0",  int'(busy0),  0);
    chk("rst_valid1", int'(valid1), 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_busy0", int'(busy0), 0);

    // 8N1 delivery
    v_before = vcnt0;
    q0.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 2);
    chk("a5_valid_cycles", vcnt0 - v_before, 1);
    chk("a5_delivered", q0.size(), 0);

    // Even parity: 0x03 has even data parity, so a 1 parity bit is an error
    q1.push_back('{d: 8'h03, p: 1'b1, f: 1'b0});
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
    idle(1, 2);
    q1.push_back('{d: 8'h03, p: 1'b0, f: 1'b0});
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
    idle(1, 2);
    // 0x07 has odd data parity; parity bit 1 makes it even
    q1.push_back('{d: 8'h07, p: 1'b0, f: 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    idle(1, 2);
    chk("par_delivered", q1.size(), 0);

    // Framing error, then held-low line must sit in break without new frames
    q0.push_back('{d: 8'h55, p: 1'b0, f: 1'b1});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    repeat (40 * 16) tick();
    chk("break_busy", int'(busy0), 1);
    chk("break_one_frame", q0.size(), 0);
    rx0 = 1'b1;
    repeat (8) tick();
    chk("break_release_busy", int'(busy0), 0);
    idle(0, 2);

    // Overrun with consumer stalled
    ready0 = 1'b0;
    v_before = ov0;
    q0.push_back('{d: 8'h11, p: 1'b0, f: 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 2);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 2);
    chk("ovr_pulses", ov0 - v_before, 1);
    chk("ovr_held_data", int'(data0), 8'h11);
    chk("ovr_held_valid", int'(valid0), 1);
    ready0 = 1'b1;
    repeat (3) tick();
    chk("ovr_valid_drop", int'(valid0), 0);
    chk("ovr_delivered", q0.size(), 0);

    // False start: 3-cycle low pulse
    rx0 = 1'b0;
    repeat (3) tick();
    rx0 = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20 && !saw_busy; i++) begin
      if (busy0) saw_busy = 1'b1;
      tick();
    end
    chk("fs_busy_rose", int'(saw_busy), 1);
    repeat (20) tick();
    chk("fs_busy_fell", int'(busy0), 0);
    chk("fs_valid", int'(valid0), 0);

`ifdef RX_MAJORITY_VOTE_EN
    // Single-cycle glitch on data bit 2's sample point is voted out
    q0.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 2);
    idle(0, 2);
`endif

    // Reset during data bit 4 of 0x3C
    b3c = 8'h3C;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, b3c[i], 1'b0);
    rx0 = b3c[4];
    repeat (8) tick();
    chk("mid_busy_before", int'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  int'(busy0),  0);
    chk("mid_rst_valid", int'(valid0), 0);
    chk("mid_rst_data",  int'(data0),  0);
    chk("mid_rst_ovr",   int'(ovr0),   0);
    rx0 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(0, 2);
    q0.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 2);

    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
